// File: rtl/ddr3_cmd_frontend.sv
// Request front end for ddr3_controller. It turns valid/ready requests into spaced rd/wr pulses,
// returns read data with a timeout guard and runs the periodic refresh schedule.
module ddr3_cmd_frontend #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 16,
    parameter int REFRESH_CYCLES = 780,
    parameter int RD_TIMEOUT     = 32,
    parameter int URGENT_OWED    = 4
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] ctl_addr,
    output logic [DATA_WIDTH-1:0] ctl_din,
    output logic                  ctl_rd,
    output logic                  ctl_wr,
    output logic                  ctl_refresh,
    input  logic [DATA_WIDTH-1:0] ctl_dout,
    input  logic                  ctl_data_ready,
    input  logic                  ctl_busy,
    output logic [3:0]            refresh_owed,
    output logic                  refresh_overflow
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(RD_TIMEOUT - 1);
    localparam logic [3:0]       OWED_MAX   = 4'd8;
    localparam logic [3:0]       URGENT     = 4'(URGENT_OWED);

    typedef enum logic [1:0] {IDLE, GAP, RD_WAIT} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_gap_first;
    logic              r_is_rd;
    logic [REF_W-1:0]  r_ref_cnt;
    logic [3:0]        r_owed;
    logic [TO_W-1:0]   r_rd_cnt;

    logic w_tick;
    logic w_ref_chosen;
    logic w_idle_go;
    logic w_issue_ref;
    logic w_accept;
    logic w_rd_done;

    assign w_tick       = (r_ref_cnt == '0);
    assign w_ref_chosen = (r_owed != 4'd0) && ((r_owed >= URGENT) || !req_valid);
    assign w_idle_go    = (r_state == IDLE) && !ctl_busy;
    assign w_issue_ref  = w_idle_go && w_ref_chosen;
    assign req_ready    = w_idle_go && !w_ref_chosen && !rst;
    assign w_accept     = req_valid && req_ready;
    assign w_rd_done    = (r_state == RD_WAIT) && (ctl_data_ready || (r_rd_cnt >= TO_LAST));
    assign refresh_owed = r_owed;

    // GAP spans the pulse cycle plus one more, so busy is never sampled before the controller can raise it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_issue_ref || w_accept) w_next_state = GAP;
            GAP:     if (!r_gap_first) w_next_state = r_is_rd ? RD_WAIT : IDLE;
            RD_WAIT: if (w_rd_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gap_first <= 1'b0;
            r_is_rd     <= 1'b0;
            r_rd_cnt    <= '0;
            ctl_rd      <= 1'b0;
            ctl_wr      <= 1'b0;
            ctl_refresh <= 1'b0;
            ctl_addr    <= '0;
            ctl_din     <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_gap_first <= (r_state == IDLE);
            ctl_rd      <= w_accept && !req_we;
            ctl_wr      <= w_accept && req_we;
            ctl_refresh <= w_issue_ref;
            if (w_accept) begin
                ctl_addr <= req_addr;
                r_is_rd  <= !req_we;
                if (req_we) ctl_din <= req_wdata;
            end else if (w_issue_ref) begin
                r_is_rd <= 1'b0;
            end
            // The read timeout counts from the ctl_rd pulse cycle, which is the first cycle after acceptance.
            if (w_accept) r_rd_cnt <= '0;
            else if (r_state != IDLE) r_rd_cnt <= r_rd_cnt + TO_W'(1);
            rsp_valid   <= w_rd_done;
            rsp_timeout <= w_rd_done && !ctl_data_ready;
            if (w_rd_done) rsp_rdata <= ctl_data_ready ? ctl_dout : '0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_ref_cnt        <= REF_RELOAD;
            r_owed           <= 4'd0;
            refresh_overflow <= 1'b0;
        end else begin
            r_ref_cnt <= w_tick ? REF_RELOAD : r_ref_cnt - REF_W'(1);
            // A tick and an issue in the same cycle cancel; a refresh is only lost when none can be issued.
            case ({w_tick, w_issue_ref})
                2'b10: begin
                    if (r_owed == OWED_MAX) refresh_overflow <= 1'b1;
                    else r_owed <= r_owed + 4'd1;
                end
                2'b01:   r_owed <= r_owed - 4'd1;
                default: r_owed <= r_owed;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_frontend.sv
// Scoreboard bench for ddr3_cmd_frontend: directed requests, a simple controller read-data model
// and a refresh-schedule model checked every cycle.
module tb_ddr3_cmd_frontend;

    localparam int AW  = 26;
    localparam int DW  = 16;
    localparam int REF = 50;

    logic          pclk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] ctl_dout = 16'hDEAD;
    logic          ctl_data_ready = 1'b0;
    logic          ctl_busy = 1'b0;
    logic          req_ready, rsp_valid, rsp_timeout, ctl_rd, ctl_wr, ctl_refresh, refresh_overflow;
    logic [DW-1:0] rsp_rdata, ctl_din;
    logic [AW-1:0] ctl_addr;
    logic [3:0]    refresh_owed;

    ddr3_cmd_frontend #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REFRESH_CYCLES(REF), .RD_TIMEOUT(32), .URGENT_OWED(4)
    ) dut (
        .pclk(pclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .ctl_addr(ctl_addr), .ctl_din(ctl_din), .ctl_rd(ctl_rd),
        .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh), .ctl_dout(ctl_dout),
        .ctl_data_ready(ctl_data_ready), .ctl_busy(ctl_busy), .refresh_owed(refresh_owed),
        .refresh_overflow(refresh_overflow)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        int            cyc;
    } cmd_t;

    typedef struct {
        bit            to;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   ref_hist[$];
    int   ref_owed_hist[$];

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            c0 = 0;
    int            rd_at = -1;
    int            rd_delay = 0;
    logic [DW-1:0] rd_val = '0;
    logic [DW-1:0] exp_din = '0;
    bit            armed = 1'b0;

    initial forever #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge pclk);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        ctl_busy = 1'b0;
        #1;
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_timeout, rsp_rdata, ctl_addr, ctl_din,
             ctl_rd, ctl_wr, ctl_refresh, refresh_owed, refresh_overflow}, '0);
        cmd_q.delete();
        rsp_q.delete();
        exp_din = '0;
        @(negedge pclk);
        @(negedge pclk);
        #1;
        rst = 1'b0;
        c0 = cyc;
        armed = 1'b1;
    endtask

    // Drives one request and returns the cycle index in which its ctl pulse is due.
    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int hs);
        int n;
        cmd_t e;
        n = 0;
        hs = -1;
        @(negedge pclk);
        #1;
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = d;
        while (hs < 0) begin
            #1;
            if (req_ready) begin
                @(posedge pclk);
                #1;
                hs = cyc;
            end else if (n >= 200) begin
                chk("handshake_timeout", 1'b0, 1'b1);
                hs = cyc;
            end else begin
                @(negedge pclk);
                #1;
                n++;
            end
        end
        if (we) exp_din = d;
        e.we = we;
        e.addr = a;
        e.din = exp_din;
        e.cyc = hs;
        cmd_q.push_back(e);
    endtask

    task automatic push_rsp(input bit to, input logic [DW-1:0] data, input int at);
        rsp_t r;
        r.to = to;
        r.data = data;
        r.cyc = at;
        rsp_q.push_back(r);
    endtask

    // Controller read-data model: one ctl_data_ready strobe rd_delay cycles after ctl_rd.
    initial forever begin
        @(negedge pclk);
        #1;
        if (rd_delay > 0 && rd_at >= 0 && cyc == rd_at + rd_delay) begin
            ctl_data_ready = 1'b1;
            ctl_dout = rd_val;
        end else begin
            ctl_data_ready = 1'b0;
            ctl_dout = 16'hDEAD;
        end
    end

    // Monitor: scoreboard pops plus a cycle-level model of the refresh schedule.
    initial begin
        int   mcnt, mowed, last_pulse;
        bit   movf, tick;
        cmd_t e;
        rsp_t r;
        mcnt = REF - 1;
        mowed = 0;
        movf = 1'b0;
        last_pulse = -100;
        forever begin
            @(negedge pclk);
            if (rst || !armed) begin
                mcnt = REF - 1;
                mowed = 0;
                movf = 1'b0;
                last_pulse = -100;
            end else begin
                tick = (mcnt == 0);
                mcnt = tick ? REF - 1 : mcnt - 1;
                if (tick && !ctl_refresh) begin
                    if (mowed == 8) movf = 1'b1;
                    else mowed++;
                end else if (!tick && ctl_refresh) begin
                    mowed--;
                end
                chk("refresh_owed", refresh_owed, mowed);
                chk("refresh_overflow", refresh_overflow, movf);
                if (ctl_wr || ctl_rd || ctl_refresh) begin
                    chk("one_pulse", int'(ctl_wr) + int'(ctl_rd) + int'(ctl_refresh), 1);
                    chk("pulse_spacing", (cyc - last_pulse) >= 2, 1'b1);
                    last_pulse = cyc;
                end
                if (ctl_wr || ctl_rd) begin
                    if (cmd_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL cmd_unexpected: actual wr=%0b rd=%0b required no pulse", ctl_wr, ctl_rd);
                    end else begin
                        e = cmd_q.pop_front();
                        chk("cmd_type_we", ctl_wr, e.we);
                        chk("cmd_addr", ctl_addr, e.addr);
                        chk("cmd_din", ctl_din, e.din);
                        chk("cmd_cycle", cyc, e.cyc);
                    end
                    if (ctl_rd) rd_at = cyc;
                end
                if (ctl_refresh) begin
                    ref_hist.push_back(cyc);
                    ref_owed_hist.push_back(int'(refresh_owed));
                end
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: actual rsp_valid=1 rdata=%0h required no response", rsp_rdata);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_timeout", rsp_timeout, r.to);
                        chk("rsp_rdata", rsp_rdata, r.data);
                        chk("rsp_cycle", cyc, r.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int hs, hs2, cnt, snap, f;
        do_reset();

        // Write then read with data returned 6 cycles after ctl_rd.
        send(1'b1, 26'h1000, 16'h1234, hs);
        req_valid = 1'b0;
        @(negedge pclk);
        chk("ready_low_wr_c1", req_ready, 1'b0);
        @(negedge pclk);
        chk("ready_low_wr_c2", req_ready, 1'b0);
        @(negedge pclk);
        chk("ready_back_after_wr", req_ready, 1'b1);
        rd_delay = 6;
        rd_val = 16'h5678;
        send(1'b0, 26'h1001, 16'h0000, hs);
        req_valid = 1'b0;
        push_rsp(1'b0, 16'h5678, hs + 7);
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge pclk);
            if (req_ready) cnt++;
        end
        chk("ready_low_during_read", cnt, 0);
        @(negedge pclk);
        chk("ready_after_rsp", req_ready, 1'b1);

        // Read timeout; the following write is accepted in the response cycle.
        do_reset();
        rd_delay = 0;
        send(1'b0, 26'h0ABC, 16'h0000, hs);
        push_rsp(1'b1, 16'h0000, hs + 32);
        send(1'b1, 26'h2000, 16'hBEEF, hs2);
        req_valid = 1'b0;
        chk("accept_after_timeout", hs2, hs + 33);
        repeat (3) @(negedge pclk);

        // Reset during RD_WAIT drops the read; late ctl_data_ready is ignored.
        do_reset();
        rd_delay = 10;
        rd_val = 16'h1111;
        send(1'b0, 26'h0555, 16'h0000, hs);
        req_valid = 1'b0;
        wait_until(hs + 4);
        do_reset();
        cnt = 0;
        while (cyc < hs + 14) begin
            @(negedge pclk);
            if (rsp_valid) cnt++;
        end
        chk("no_rsp_after_reset", cnt, 0);
        chk("owed_after_reset", refresh_owed, 4'd0);
        chk("idle_after_reset", req_ready, 1'b1);
        rd_delay = 0;

        // Continuous writes: owed reaches 4 at cycle 200, refresh then preempts.
        do_reset();
        snap = ref_hist.size();
        for (int i = 0; cyc < c0 + 260; i++) begin
            send(1'b1, AW'(26'h3000 + i), DW'(16'hA000 + i), hs);
        end
        req_valid = 1'b0;
        chk("refs_during_stream", ref_hist.size() - snap, 2);
        chk("owed_after_stream", refresh_owed, 4'd3);
        if (ref_hist.size() > snap) begin
            f = ref_hist[snap] - c0;
            chk("first_ref_window", (f >= 201) && (f <= 203), 1'b1);
            chk("owed_at_first_ref", ref_owed_hist[snap], 3);
        end
        repeat (20) @(negedge pclk);
        chk("owed_drained", refresh_owed, 4'd0);
        chk("refs_after_drain", ref_hist.size() - snap, 5);

        // Refresh issued in the same cycle as a tick leaves owed unchanged.
        do_reset();
        ctl_busy = 1'b1;
        wait_until(c0 + 50);
        chk("owed_first_tick", refresh_owed, 4'd1);
        wait_until(c0 + 99);
        #1;
        ctl_busy = 1'b0;
        wait_until(c0 + 100);
        chk("coincide_pulse", ctl_refresh, 1'b1);
        chk("coincide_owed", refresh_owed, 4'd1);
        wait_until(c0 + 103);
        chk("second_ref_pulse", ctl_refresh, 1'b1);
        chk("second_ref_owed", refresh_owed, 4'd0);

        // Busy for 10 ticks: owed saturates at 8, overflow sticks until reset.
        do_reset();
        ctl_busy = 1'b1;
        snap = ref_hist.size();
        wait_until(c0 + 449);
        chk("owed_saturated", refresh_owed, 4'd8);
        chk("no_overflow_yet", refresh_overflow, 1'b0);
        chk("no_ref_while_busy", ref_hist.size() - snap, 0);
        wait_until(c0 + 450);
        chk("overflow_set", refresh_overflow, 1'b1);
        wait_until(c0 + 505);
        #1;
        ctl_busy = 1'b0;
        wait_until(c0 + 540);
        chk("owed_drained_ovf", refresh_owed, 4'd0);
        chk("overflow_sticky", refresh_overflow, 1'b1);
        do_reset();
        @(negedge pclk);
        chk("overflow_cleared", refresh_overflow, 1'b0);

        chk("cmd_q_empty", cmd_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_frontend.md
Name: ddr3_cmd_frontend

Overview:
Request front end sitting directly upstream of ddr3_controller in the pclk domain. It takes user read/write requests over a valid/ready handshake and converts them into single-cycle rd/wr pulses that respect the controller's busy signal. It returns read data with a timeout guard. It also owns the periodic refresh schedule, issuing refresh pulses and tracking postponed refreshes (max 8, per DDR3).

Parameters:
ADDR_WIDTH, 26, user/controller address width
DATA_WIDTH, 16, data width
REFRESH_CYCLES, 780, pclk cycles per refresh interval (7.8us at 100MHz)
RD_TIMEOUT, 32, pclk cycles to wait for ctl_data_ready after ctl_rd
URGENT_OWED, 4, owed-refresh count at which refresh preempts requests

Ports:
pclk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  user request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle read-response strobe
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_timeout  out  1  qualifies rsp_valid: read timed out, rsp_rdata=0
ctl_addr  out  ADDR_WIDTH  to controller addr
ctl_din  out  DATA_WIDTH  to controller din
ctl_rd  out  1  one-cycle read pulse
ctl_wr  out  1  one-cycle write pulse
ctl_refresh  out  1  one-cycle refresh pulse
ctl_dout  in  DATA_WIDTH  controller read data
ctl_data_ready  in  1  controller read-data strobe
ctl_busy  in  1  controller busy
refresh_owed  out  4  postponed refreshes, 0..8
refresh_overflow  out  1  sticky: a tick arrived with owed=8

Behaviour:
- Reset (async, immediate): all outputs 0. State=IDLE. Refresh counter loads REFRESH_CYCLES-1. Owed=0. Overflow cleared. An in-flight read is dropped and produces no rsp_valid.
- Refresh timer:
  - Free-running down-counter. At 0 it reloads and generates a tick.
  - A tick increments owed, saturating at 8. A tick while owed=8 sets refresh_overflow.
  - An issued refresh decrements owed. A tick and an issue in the same cycle leave owed unchanged.
- States: IDLE, GAP, RD_WAIT.
- IDLE, when ctl_busy=0, decides in this priority order:
  1. Refresh if owed>=URGENT_OWED, or if owed>0 and req_valid=0.
  2. Otherwise the request handshake.
- req_ready = (state==IDLE) & ~ctl_busy & ~refresh_chosen (combinational from registered state and ctl_busy).
- Handshake at cycle N:
  - ctl_addr/ctl_din register req_addr/req_wdata; ctl_din is updated only for writes.
  - ctl_wr or ctl_rd is high for exactly cycle N+1.
  - ctl_addr/ctl_din hold until the next accepted request.
- Refresh chosen at cycle N: ctl_refresh is high for exactly cycle N+1.
- After any pulse:
  - GAP lasts 1 cycle, with ctl_busy ignored, to cover the controller's busy rise latency.
  - Then a write or refresh goes to IDLE; a read goes to RD_WAIT.
- RD_WAIT:
  - Cycle count starts on the ctl_rd cycle.
  - First cycle with ctl_data_ready=1: rsp_rdata<=ctl_dout, rsp_valid=1 for one cycle, rsp_timeout=0, go to IDLE.
  - If RD_TIMEOUT cycles pass with no ctl_data_ready: rsp_valid=1, rsp_timeout=1, rsp_rdata=0, go to IDLE.
  - ctl_data_ready outside RD_WAIT is ignored.
- rsp_rdata holds its value between responses.
- At most one command is outstanding. No request queueing; backpressure is only through req_ready.
- No two ctl_* pulses are ever closer than 2 cycles apart. No pulse is issued while ctl_busy=1 in IDLE.

Test Plan:
- Reset then write 0x1000/0x1234 with ctl_busy=0 → ctl_wr high exactly 1 cycle after handshake; ctl_addr=0x1000, ctl_din=0x1234; req_ready low for the next 2 cycles.
- Read 0x1001 with model returning 0x5678 and ctl_data_ready 6 cycles after ctl_rd → one rsp_valid with rsp_rdata=0x5678, rsp_timeout=0; req_ready low until then.
- Read with ctl_data_ready never asserted, RD_TIMEOUT=32 → rsp_valid with rsp_timeout=1, rsp_rdata=0 exactly 32 cycles after ctl_rd; the next request is then accepted.
- REFRESH_CYCLES=50, req_valid held high continuously → owed climbs to 4 at cycle ~200, then ctl_refresh preempts one request, owed drops to 3; with req_valid=0 all owed refreshes drain to 0.
- Refresh issue coinciding with a timer tick → owed unchanged. ctl_busy held high for 10 ticks → owed saturates at 8 and refresh_overflow=1 (sticky until rst).
- Assert rst during RD_WAIT, then deliver ctl_data_ready → all outputs 0 immediately; no rsp_valid; owed=0; state IDLE.
